// File: rtl/melody_pkg.sv
// melody_pkg: shared note codes, FSM states, period table and default song
// for the melody scheduler.
package melody_pkg;

    localparam int unsigned NOTE_W    = 3;
    localparam int unsigned DUR_W     = 3;
    localparam int unsigned ENTRY_W   = NOTE_W + DUR_W;
    localparam int unsigned PER_W     = 16;
    localparam int unsigned NUM_NOTES = 7;
    localparam int unsigned DEF_LEN   = 16;

    // Note codes stored in entry[5:3]; 0 is a rest.
    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO4  = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE4  = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI4  = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA4  = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_SOL4 = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA4  = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI4  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    // Full square-wave periods in 12 MHz clock cycles.
    localparam logic [PER_W-1:0] PER_DO4  = 16'd45866;
    localparam logic [PER_W-1:0] PER_RE4  = 16'd40863;
    localparam logic [PER_W-1:0] PER_MI4  = 16'd36404;
    localparam logic [PER_W-1:0] PER_FA4  = 16'd34361;
    localparam logic [PER_W-1:0] PER_SOL4 = 16'd30612;
    localparam logic [PER_W-1:0] PER_LA4  = 16'd27273;
    localparam logic [PER_W-1:0] PER_SI4  = 16'd24297;

    // Period of note code k lives at slice [(k-1)*PER_W +: PER_W].
    localparam logic [NUM_NOTES*PER_W-1:0] DEF_PERIODS = {
        PER_SI4, PER_LA4, PER_SOL4, PER_FA4, PER_MI4, PER_RE4, PER_DO4
    };

    function automatic logic [ENTRY_W-1:0] mk_entry(
        input logic [NOTE_W-1:0] note,
        input logic [DUR_W-1:0]  dur
    );
        return {note, dur};
    endfunction

    // Entry i lives at slice [i*ENTRY_W +: ENTRY_W]; dur 0 ends the song.
    localparam logic [DEF_LEN*ENTRY_W-1:0] DEF_SONG = {
        {((DEF_LEN - 4) * ENTRY_W){1'b0}},
        mk_entry(NOTE_REST, 3'd0),
        mk_entry(NOTE_MI4,  3'd3),
        mk_entry(NOTE_REST, 3'd1),
        mk_entry(NOTE_DO4,  3'd2)
    };

endpackage

// File: rtl/melody_sched_tone_div.sv
// tone_div: variable-period square-wave generator, high for the first
// period/2 counts of each period; phase_rst restarts the wave at count 0.
module tone_div
    import melody_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             phase_rst,
    input  logic [PER_W-1:0] period,
    output logic             sq
);

    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] half;

    assign half = period >> 1;
    assign sq   = (cnt < half);

    // Free-running period counter; a zero period simply holds at 0.
    always_ff @(posedge clk_in) begin
        if (rst || phase_rst) begin
            cnt <= '0;
        end else if (({1'b0, cnt} + (PER_W + 1)'(1)) >= {1'b0, period}) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/melody_sched.sv
// melody_sched: plays a song ROM of (note, duration) entries as a square
// wave, with a silent gap after each note.
// Define MELODY_LOOP_EN to replay the song continuously instead of ending.
module melody_sched
    import melody_pkg::*;
#(
    parameter int unsigned TICK_DIV = 3_000_000,
    parameter int unsigned GAP_CYC  = 120_000,
    parameter int unsigned LEN      = 16,
    parameter logic [LEN*ENTRY_W-1:0]     SONG         = DEF_SONG,
    parameter logic [NUM_NOTES*PER_W-1:0] NOTE_PERIODS = DEF_PERIODS
)(
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    tone,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LEN)-1:0]  note_idx
);

    localparam int unsigned IDX_W = $clog2(LEN);
    localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             state;
    logic [DUR_W-1:0]   remaining;
    logic [TW-1:0]      tick_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [PER_W-1:0]   period_q;
    logic               tone_en;
    logic               past_end;
    logic               sq;

    logic [ENTRY_W-1:0] entry;
    logic [NOTE_W-1:0]  cur_note;
    logic [DUR_W-1:0]   cur_dur;
    logic [PER_W-1:0]   per_sel;
    logic               last_idx;

    assign entry    = SONG[note_idx*ENTRY_W +: ENTRY_W];
    assign cur_note = entry[ENTRY_W-1:DUR_W];
    assign cur_dur  = entry[DUR_W-1:0];
    assign last_idx = (note_idx == IDX_W'(LEN - 1));
    assign tone     = tone_en & sq;

    // Period lookup for the entry being loaded; rests map to period 0.
    always_comb begin
        per_sel = '0;
        if (cur_note != NOTE_REST) begin
            per_sel = NOTE_PERIODS[(int'(cur_note) - 1) * PER_W +: PER_W];
        end
    end

    // Song sequencing FSM with registered busy/done/note_idx/tone enable.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
            remaining <= '0;
            tick_cnt  <= '0;
            gap_cnt   <= '0;
            period_q  <= '0;
            tone_en   <= 1'b0;
            past_end  <= 1'b0;
        end else if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
            tone_en  <= 1'b0;
            past_end <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        note_idx <= '0;
                        past_end <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if ((cur_dur == '0) || past_end) begin
`ifdef MELODY_LOOP_EN
                        state    <= ST_LOAD;
                        note_idx <= '0;
                        past_end <= 1'b0;
`else
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        state     <= ST_PLAY;
                        period_q  <= per_sel;
                        remaining <= cur_dur;
                        tick_cnt  <= '0;
                        tone_en   <= (cur_note != NOTE_REST);
                    end
                end
                ST_PLAY: begin
                    if (tick_cnt == TW'(TICK_DIV - 1)) begin
                        tick_cnt <= '0;
                        if (remaining == DUR_W'(1)) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            tone_en <= 1'b0;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        state <= ST_LOAD;
                        // Running off the last ROM slot is flagged rather than
                        // wrapping the index, so LOAD can end the song.
                        if (last_idx) begin
                            past_end <= 1'b1;
                        end else begin
                            note_idx <= note_idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    tone_div u_tone_div (
        .clk_in    (clk_in),
        .rst       (rst),
        .phase_rst (state == ST_LOAD),
        .period    (period_q),
        .sq        (sq)
    );

endmodule
